// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state names (common with the receiver),
// default line/clock rates and the bit-period helper.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } uart_state_e;

   localparam int DEFAULT_BAUD_RATE = 115200;
   localparam int DEFAULT_CLK_RATE  = 25000000;

   // Whole clk cycles per line bit; the remainder is dropped, not accumulated.
   function automatic int clk_per_bit(input int clk_rate, input int baud_rate);
      return clk_rate / baud_rate;
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: while enabled, pulses tick for one cycle every
// CLK_PER_BIT cycles; held at zero while disabled.
module uart_baud_tick #(
   parameter int CLK_PER_BIT = 10
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   output logic tick
);

   localparam int CW = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_PER_BIT - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign tick = en && (cnt_q == LAST);

   always_comb begin
      if (!en || tick) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the pre-edge value regardless of block ordering.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: valid/ready word in, LSB-first start/data/stop frame out
// on an idle-high line. Define UART_TX_PARITY_EN to insert a parity bit.
module uart_tx
   import uart_pkg::*;
#(
   parameter int BAUD_RATE  = DEFAULT_BAUD_RATE,
   parameter int DATA_BITS  = 8,
   parameter int STOP_BITS  = 1,
   parameter int CLK_RATE   = DEFAULT_CLK_RATE,
   parameter int PARITY_ODD = 0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 tx_valid,
   input  logic [DATA_BITS-1:0] tx_data,
   output logic                 tx_ready,
   output logic                 tx_busy,
   output logic                 tx
);

   localparam int CLK_PER_BIT = clk_per_bit(CLK_RATE, BAUD_RATE);
   localparam int BW          = $clog2(DATA_BITS + 1);
   localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
   localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

   if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("uart_tx: DATA_BITS must be 5..9");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
      $error("uart_tx: STOP_BITS must be 1 or 2");
   end
   if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_parity_odd
      $error("uart_tx: PARITY_ODD must be 0 or 1");
   end
   if (CLK_PER_BIT < 1) begin : g_bad_rate
      $error("uart_tx: CLK_RATE must be at least BAUD_RATE");
   end

   uart_state_e          state_q, state_d;
   logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 tx_q, tx_d;
   logic                 tx_ready_q, tx_ready_d;
   logic                 tx_busy_q, tx_busy_d;
   logic                 tick;
`ifdef UART_TX_PARITY_EN
   logic                 parity_q, parity_d;
`endif

   uart_baud_tick #(
      .CLK_PER_BIT(CLK_PER_BIT)
   ) u_baud_tick (
      .clk  (clk),
      .reset(reset),
      .en   (state_q != IDLE),
      .tick (tick)
   );

   // tx_d is the line level for the state being entered, so tx stays registered.
   always_comb begin
      // NOTE: every signal gets a default first; a path that leaves one
      // unassigned would infer a latch.
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      tx_d      = tx_q;
`ifdef UART_TX_PARITY_EN
      parity_d  = parity_q;
`endif
      unique case (state_q)
         IDLE: begin
            tx_d = 1'b1;
            if (tx_valid && tx_ready_q) begin
               shift_d   = tx_data;
               bit_cnt_d = '0;
               state_d   = START;
               tx_d      = 1'b0;
`ifdef UART_TX_PARITY_EN
               parity_d  = (^tx_data) ^ 1'(PARITY_ODD);
`endif
            end
         end
         START: begin
            if (tick) begin
               state_d = DATA;
               tx_d    = shift_q[0];
            end
         end
         DATA: begin
            if (tick) begin
               if (bit_cnt_q == DATA_LAST) begin
                  bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
                  state_d   = PARITY;
                  tx_d      = parity_q;
`else
                  state_d   = STOP;
                  tx_d      = 1'b1;
`endif
               end else begin
                  bit_cnt_d = bit_cnt_q + BW'(1);
                  shift_d   = shift_q >> 1;
                  tx_d      = shift_q[1];
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (tick) begin
               state_d = STOP;
               tx_d    = 1'b1;
            end
         end
`endif
         STOP: begin
            tx_d = 1'b1;
            if (tick) begin
               if (bit_cnt_q == STOP_LAST) begin
                  bit_cnt_d = '0;
                  state_d   = IDLE;
               end else begin
                  bit_cnt_d = bit_cnt_q + BW'(1);
               end
            end
         end
         default: begin
            state_d = IDLE;
            tx_d    = 1'b1;
         end
      endcase
      tx_ready_d = (state_d == IDLE);
      tx_busy_d  = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         bit_cnt_q  <= '0;
         tx_q       <= 1'b1;
         tx_ready_q <= 1'b1;
         tx_busy_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         tx_q       <= tx_d;
         tx_ready_q <= tx_ready_d;
         tx_busy_q  <= tx_busy_d;
      end
      // NOTE: the word register is pure datapath, loaded before it is ever
      // read, so it is deliberately left out of reset.
      shift_q <= shift_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
   end

   assign tx       = tx_q;
   assign tx_ready = tx_ready_q;
   assign tx_busy  = tx_busy_q;

endmodule
